// File: rtl/crc_pkg.sv
// Shared constants, FSM states and the byte-wise CRC-32 step
// used by the serial Ethernet FCS checker.
package crc_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_BODY,
        ST_FCS
    } crc_state_e;

    // Reflected CRC-32: byte enters LSB first, eight serial steps.
    function automatic logic [31:0] crc32_byte_update(
        input logic [31:0] crc,
        input logic [7:0]  data
    );
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) c = (c >> 1) ^ CRC32_POLY_REFL;
            else      c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_byte_engine.sv
// Registered CRC-32 accumulator: loads the init value or
// folds in one byte per enabled cycle.
module crc32_byte_engine
    import crc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    // Next CRC: init wins over a byte update.
    always_comb begin
        crc_d = crc_q;
        if (init_i) begin
            crc_d = CRC32_INIT;
        end else if (en_i) begin
            crc_d = crc32_byte_update(crc_q, byte_i);
        end
    end

    // CRC register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) crc_q <= CRC32_INIT;
        else         crc_q <= crc_d;
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/serial_crc_checker.sv
// Bit-serial Ethernet FCS checker: skips the preamble, runs
// CRC-32 over body and FCS, flags bad or malformed frames.
module serial_crc_checker
    import crc_pkg::*;
#(
    parameter int packet_byte_size_max = 89,
    parameter int PREAMBLE_BYTES       = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start_of_frame,
    input  logic end_of_frame,
    input  logic data_in,
    output logic fcs_error
);

    localparam int CNT_W = $clog2(packet_byte_size_max + 1);

    crc_state_e     state_q, state_d;
    logic [2:0]     bit_q, bit_d;
    logic [CNT_W-1:0] byte_q, byte_d;
    logic [2:0]     fcs_q, fcs_d;
    logic [7:0]     sr_q, sr_d;
    logic           err_q, err_d;

    logic           crc_init;
    logic           crc_en;
    logic [31:0]    crc;
    logic [7:0]     sample;
    logic           byte_done;
    logic           over;
    logic [CNT_W-1:0] byte_inc;

    assign sample    = {sr_q[6:0], data_in};
    assign byte_done = (bit_q == 3'd7);
    assign over      = byte_done &&
                       (byte_q == CNT_W'(packet_byte_size_max));
    assign byte_inc  = (&byte_q) ? byte_q : byte_q + CNT_W'(1);

    crc32_byte_engine u_crc (
        .clk_i  (clk),
        .rst_ni (reset),
        .init_i (crc_init),
        .en_i   (crc_en),
        .byte_i (sample),
        .crc_o  (crc)
    );

    // Frame FSM, byte assembly, counters and error decision.
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        fcs_d    = fcs_q;
        sr_d     = sr_q;
        err_d    = err_q;
        crc_init = 1'b0;
        crc_en   = 1'b0;
        if (start_of_frame) begin
            state_d  = ST_SKIP;
            bit_d    = '0;
            byte_d   = '0;
            fcs_d    = '0;
            sr_d     = '0;
            err_d    = 1'b0;
            crc_init = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_SKIP: begin
                    if (end_of_frame) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        sr_d  = sample;
                        bit_d = bit_q + 3'd1;
                        if (byte_done) begin
                            byte_d = byte_inc;
                            if (over) begin
                                err_d   = 1'b1;
                                state_d = ST_IDLE;
                            end else if (byte_q ==
                                CNT_W'(PREAMBLE_BYTES - 1)) begin
                                state_d = ST_BODY;
                            end
                        end
                    end
                end
                ST_BODY: begin
                    if (end_of_frame && (bit_q != 3'd0 ||
                        byte_q == CNT_W'(PREAMBLE_BYTES))) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        sr_d  = sample;
                        bit_d = bit_q + 3'd1;
                        if (end_of_frame) state_d = ST_FCS;
                        if (byte_done) begin
                            byte_d = byte_inc;
                            crc_en = 1'b1;
                            if (over) begin
                                err_d   = 1'b1;
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
                ST_FCS: begin
                    if (fcs_q == 3'd4) begin
                        err_d   = (crc != CRC32_RESIDUE);
                        state_d = ST_IDLE;
                    end else begin
                        sr_d  = sample;
                        bit_d = bit_q + 3'd1;
                        if (byte_done) begin
                            byte_d = byte_inc;
                            crc_en = 1'b1;
                            fcs_d  = fcs_q + 3'd1;
                            if (over) begin
                                err_d   = 1'b1;
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            byte_q  <= '0;
            fcs_q   <= '0;
            sr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            fcs_q   <= fcs_d;
            sr_q    <= sr_d;
            err_q   <= err_d;
        end
    end

    assign fcs_error = err_q;

endmodule

// File: tb/tb_serial_crc_checker.sv
// Directed bench for serial_crc_checker with a bit-serial
// reference CRC and an expected-result queue.
module tb_serial_crc_checker;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sof = 1'b0;
    logic eof = 1'b0;
    logic din = 1'b0;
    logic fcs_err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string tag;
        logic  exp;
    } exp_t;

    exp_t sb[$];
    logic [7:0] body_q[$];
    logic [31:0] fcs_good;

    always #5 clk = ~clk;

    serial_crc_checker dut (
        .clk            (clk),
        .reset          (reset),
        .start_of_frame (sof),
        .end_of_frame   (eof),
        .data_in        (din),
        .fcs_error      (fcs_err)
    );

    // Independent bit-at-a-time reflected CRC-32 over body_q.
    function automatic logic [31:0] model_fcs();
        logic [31:0] c;
        logic fb;
        c = 32'hFFFF_FFFF;
        foreach (body_q[k]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[0] ^ body_q[k][i];
                c = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    task automatic push(input string tag, input logic e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic check_out();
        exp_t x;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%b", fcs_err);
        end else begin
            x = sb.pop_front();
            assert (fcs_err === x.exp) else begin
                failures++;
                $error("FAIL %s observed=%b expected=%b",
                       x.tag, fcs_err, x.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic e);
        din = b;
        eof = e;
        tick();
        eof = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input logic e);
        for (int i = 7; i >= 0; i--) send_bit(v[i], e && (i == 7));
    endtask

    task automatic start(input logic with_eof);
        sof = 1'b1;
        eof = with_eof;
        din = 1'b1;
        tick();
        sof = 1'b0;
        eof = 1'b0;
    endtask

    task automatic preamble();
        for (int i = 0; i < 8; i++) send_byte(8'hFF, 1'b0);
    endtask

    // Whole frame; returns just after the edge taking the last FCS bit.
    task automatic send_frame(input logic [31:0] fcs, input logic se);
        start(se);
        preamble();
        foreach (body_q[k]) send_byte(body_q[k], 1'b0);
        send_byte(fcs[7:0], 1'b1);
        send_byte(fcs[15:8], 1'b0);
        send_byte(fcs[23:16], 1'b0);
        send_byte(fcs[31:24], 1'b0);
    endtask

    task automatic load_spec_body();
        body_q = '{8'h00, 8'h10, 8'hA4, 8'h7B, 8'hEA, 8'h80, 8'h00,
                   8'h12, 8'h34, 8'h56, 8'h78, 8'h90, 8'h08, 8'h00,
                   8'h45, 8'h00, 8'h00, 8'h2E, 8'hB3, 8'hFE, 8'h00,
                   8'h00, 8'h80, 8'h11, 8'h05, 8'h40, 8'hC0, 8'hA8,
                   8'h00, 8'h2C, 8'hC0, 8'hA8, 8'h00, 8'h04, 8'h04,
                   8'h00, 8'h04, 8'h00, 8'h00, 8'h1A, 8'h2D, 8'hE8,
                   8'h00, 8'h01};
        for (int v = 2; v <= 17; v++) body_q.push_back(8'(v));
    endtask

    initial begin
        // Reset state.
        tick();
        tick();
        push("reset_state", 1'b0);
        check_out();
        reset = 1'b1;
        tick();

        // Good frame: result on the 33rd edge, then held.
        load_spec_body();
        fcs_good = model_fcs();
        send_frame(fcs_good, 1'b0);
        push("good_edge33", 1'b0);
        tick();
        check_out();
        repeat (10000) tick();
        push("good_hold_10000", 1'b0);
        check_out();

        // Bad FCS: not before edge 33, then held through IDLE traffic.
        send_frame(fcs_good ^ 32'h0100_0000, 1'b0);
        push("badfcs_edge32", 1'b0);
        check_out();
        tick();
        push("badfcs_edge33", 1'b1);
        check_out();
        repeat (50) tick();
        send_byte(8'h5A, 1'b1);
        send_byte(8'hC3, 1'b0);
        push("badfcs_hold_idle", 1'b1);
        check_out();
        start(1'b0);
        push("sof_clears", 1'b0);
        check_out();

        // Single body bit flipped.
        body_q[14] = 8'h44;
        send_frame(fcs_good, 1'b0);
        tick();
        push("bitflip", 1'b1);
        check_out();
        body_q[14] = 8'h45;

        // Back-to-back: next start_of_frame right after the result.
        send_frame(fcs_good, 1'b0);
        tick();
        push("back_to_back_good", 1'b0);
        check_out();

        // end_of_frame after 3 body bits, then IDLE ignores traffic.
        start(1'b0);
        preamble();
        send_byte(8'h12, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        push("eof_midbyte", 1'b1);
        check_out();
        for (int i = 0; i < 6; i++) send_byte(8'(i * 37), i == 1);
        push("eof_midbyte_idle", 1'b1);
        check_out();

        // end_of_frame during the preamble.
        start(1'b0);
        push("sof_clears_2", 1'b0);
        check_out();
        for (int i = 0; i < 3; i++) send_byte(8'hFF, 1'b0);
        send_bit(1'b1, 1'b1);
        push("eof_in_skip", 1'b1);
        check_out();

        // end_of_frame with no body bytes.
        start(1'b0);
        preamble();
        push("zero_body_pre", 1'b0);
        check_out();
        send_bit(1'b0, 1'b1);
        push("zero_body", 1'b1);
        check_out();

        // start_of_frame wins over a simultaneous end_of_frame.
        send_frame(fcs_good, 1'b1);
        tick();
        push("sof_beats_eof", 1'b0);
        check_out();

        // 89 bytes total with a valid CRC is accepted.
        body_q.delete();
        for (int i = 0; i < 77; i++) body_q.push_back(8'($urandom));
        send_frame(model_fcs(), 1'b0);
        tick();
        push("size_89_ok", 1'b0);
        check_out();

        // 90 bytes total is rejected at byte 90.
        body_q.push_back(8'($urandom));
        send_frame(model_fcs(), 1'b0);
        push("size_90_err", 1'b1);
        check_out();

        // Asynchronous reset clears a held error with no clock edge.
        @(negedge clk);
        reset = 1'b0;
        #1;
        push("async_reset_clear", 1'b0);
        check_out();
        tick();
        reset = 1'b1;
        start(1'b0);
        push("sof_clears_3", 1'b0);
        check_out();

        // Reset mid-body discards the frame silently.
        load_spec_body();
        start(1'b0);
        preamble();
        for (int i = 0; i < 10; i++) send_byte(body_q[i], 1'b0);
        reset = 1'b0;
        #2;
        push("reset_midbody", 1'b0);
        check_out();
        tick();
        reset = 1'b1;
        for (int i = 10; i < 60; i++) send_byte(body_q[i], 1'b0);
        send_byte(8'h00, 1'b1);
        repeat (40) tick();
        push("reset_midbody_rest", 1'b0);
        check_out();
        send_frame(fcs_good, 1'b0);
        tick();
        push("good_after_reset", 1'b0);
        check_out();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_crc_checker.md
# serial_crc_checker

Bit-serial Ethernet FCS checker on the receive path, after the PHY-side deserialiser and before frame buffering. It takes one bit per clock, skips a fixed-length preamble, and runs IEEE 802.3 CRC-32 over the frame body and the trailing 4-byte FCS. At frame end it drives a sticky error flag for the switch's drop logic.

## Interface
Parameters:
- `packet_byte_size_max`, default 89: maximum bytes accepted after `start_of_frame`, counting preamble, body and FCS; longer frames are errors.
- `PREAMBLE_BYTES`, default 8: bytes after `start_of_frame` that are excluded from the CRC.

Ports:
- `clk`, input, 1: the single clock; all logic on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `start_of_frame`, input, 1: one-cycle pulse; its own-cycle `data_in` is ignored.
- `end_of_frame`, input, 1: one-cycle pulse, coincident with the first FCS bit.
- `data_in`, input, 1: serial data, MSB of each byte first.
- `fcs_error`, output, 1: registered; 1 = CRC mismatch or malformed frame; 0 = frame good or none checked yet.

## Operation
- States:
  - IDLE
  - SKIP: preamble
  - BODY
  - FCS
- Any state, `start_of_frame`=1 → SKIP; bit and byte counters clear, CRC register loads 0xFFFFFFFF, `fcs_error` clears to 0. An in-progress frame is abandoned. `start_of_frame` wins over a simultaneous `end_of_frame`.
- Byte assembly: 8-bit shift register, MSB first. A byte completes on every 8th sampled bit.
- SKIP: discard `PREAMBLE_BYTES` complete bytes, then → BODY.
- BODY: each completed byte updates the CRC. Update is reflected CRC-32, polynomial 0x04C11DB7 (0xEDB88320 reflected), byte processed LSB first: 8 serial steps applied combinationally.
- `end_of_frame` sampled in BODY with the bit counter on a byte boundary → FCS. That bit is FCS bit 0.
- FCS: the next 32 bits (4 bytes) also update the CRC. After the 4th FCS byte:
  - `fcs_error` = (CRC register ≠ residue 0xDEBB20E3).
  - → IDLE.
- Error conditions; each sets `fcs_error`=1 and → IDLE:
  - `end_of_frame` in SKIP, or mid-byte in BODY.
  - `end_of_frame` with zero body bytes.
  - Byte count exceeding `packet_byte_size_max`.
- IDLE: ignore `data_in` and `end_of_frame`; hold `fcs_error` until the next `start_of_frame`.

## Timing
- Reset (`reset`=0, asynchronous): state IDLE, counters 0, CRC 0xFFFFFFFF, shift register 0, `fcs_error`=0.
- Reset mid-frame: the frame is discarded; no error is reported.
- First data bit is sampled at the edge after the `start_of_frame` edge.
- CRC update happens at the edge where a byte's 8th bit is sampled.
- Latency: `fcs_error` is valid 1 cycle after the edge sampling the last FCS bit, i.e. edge 33 counted from the `end_of_frame` edge.
- Byte counter width is $clog2(`packet_byte_size_max`+1) and saturates.
- Back-to-back frames are allowed: `start_of_frame` may arrive on the cycle after the result.

## Structure
- Package `crc_pkg`:
  - `CRC32_POLY_REFL` = 0xEDB88320
  - `CRC32_INIT` = 0xFFFFFFFF
  - `CRC32_RESIDUE` = 0xDEBB20E3
  - state enum typedef
  - pure function `crc32_byte_update(crc, byte)`
- One natural sub-module, `crc32_byte_engine`: registered CRC with load-init and byte-enable inputs. The top holds the FSM, counters and byte assembler.

## Test plan
- Good frame, bit-exact on the wire:
  - `start_of_frame`, then 8×0xFF preamble, then 60 body bytes `00 10 A4 7B EA 80 00 12 34 56 78 90 08 00 45 00 00 2E B3 FE 00 00 80 11 05 40 C0 A8 00 2C C0 A8 00 04 04 00 04 00 00 1A 2D E8 00 01 … 11`.
  - Then `end_of_frame` with FCS `E6 C5 3D B2`, all bytes sent MSB first.
  - Required response: `fcs_error`=0 at 33 cycles and still 0 after 10000 cycles.
- Same frame with FCS byte 3 = 0xB3 → `fcs_error`=1, held until the next `start_of_frame`.
- Single body bit flipped (byte 0x45 → 0x44) → `fcs_error`=1.
- `end_of_frame` after 3 body bits → `fcs_error`=1 on the next edge, state IDLE.
- Frame of 90 bytes total → `fcs_error`=1 at byte 90. A new `start_of_frame` clears it to 0.
- `reset` low mid-body → `fcs_error`=0 immediately. The subsequent good frame passes with 0.
